uart_rx_fifo: RTL and testbench

//   Parametrised UART receiver with an error-tagged receive FIFO and a valid/ready output handshake.

---
 rtl/uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with an error-tagged receive FIFO and a valid/ready output handshake.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_fifo #(
    parameter int    CLK_DIV   = 217,
    parameter int    DATA_BITS = 8,
    parameter string PARITY    = "NONE",
    parameter int    STOP_BITS = 1,
    parameter int    ASIZE     = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_en,
    input  logic       rx_rdy,
    output logic       rx_overflow,
    input  logic       ovf_clr,
    output logic       rx_break
);

    localparam int             CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  HALF_C  = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0]  LAST_C  = CW'(CLK_DIV - 1);
    localparam logic [2:0]     DLAST_C = 3'(DATA_BITS - 1);
    localparam logic [2:0]     SLAST_C = 3'(STOP_BITS - 1);
    localparam bit             ODD_PAR = (PARITY == "ODD");
    localparam bit             HAS_PAR = (PARITY == "ODD") || (PARITY == "EVEN");
    localparam int             DEPTH   = 2 ** ASIZE;

`ifdef UART_RX_BREAK_DETECT_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4, S_WAIT_HIGH = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4
    } state_t;
`endif

    // Parity error over data plus received parity bit.
    function automatic logic par_err(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = ^{d, p};
        if (!HAS_PAR) begin
            return 1'b0;
        end else if (ODD_PAR) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

    state_t                 state_r, state_s;
    logic                   sync1_r, sync2_r, prev_r;
    logic [CW-1:0]          cnt_r;
    logic [2:0]             bit_r;
    logic [DATA_BITS-1:0]   data_r;
    logic                   perr_r, ferr_r;
    logic                   fall_s, sample_s, push_s;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                   pbit_r, brk_s, brk_r;
`endif

    logic [9:0]             mem_r [DEPTH];
    logic [ASIZE:0]         wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s;
    logic [9:0]             wdata_s;
    logic                   full_s, pop_s, acc_s;
    logic                   rx_en_r, ovf_r, perr_out_r, ferr_out_r;
    logic [7:0]             data_out_r;

    assign fall_s   = prev_r & ~sync2_r;
    assign sample_s = (state_r == S_START) ? (cnt_r == HALF_C) : (cnt_r == LAST_C);

    // Next-state and frame-completion strobes.
    always_comb begin
        state_s = state_r;
        push_s  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_s   = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                if (fall_s) state_s = S_START;
                else        state_s = S_IDLE;
            end
            S_START: begin
                if (sample_s) state_s = sync2_r ? S_IDLE : S_DATA;
                else          state_s = S_START;
            end
            S_DATA: begin
                if (sample_s && bit_r == DLAST_C) state_s = HAS_PAR ? S_PAR : S_STOP;
                else                              state_s = S_DATA;
            end
            S_PAR: begin
                if (sample_s) state_s = S_STOP;
                else          state_s = S_PAR;
            end
            S_STOP: begin
                if (sample_s) begin
`ifdef UART_RX_BREAK_DETECT_EN
                    if (bit_r == 3'd0 && !sync2_r && data_r == {DATA_BITS{1'b0}} && !pbit_r) begin
                        brk_s   = 1'b1;
                        state_s = S_WAIT_HIGH;
                    end else
`endif
                    if (bit_r == SLAST_C) begin
                        push_s  = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_STOP;
                    end
                end else begin
                    state_s = S_STOP;
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            S_WAIT_HIGH: begin
                if (sync2_r) state_s = S_IDLE;
                else         state_s = S_WAIT_HIGH;
            end
`endif
            default: state_s = S_IDLE;
        endcase
    end

    // Line synchroniser, bit timing and frame accumulation.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
            state_r <= S_IDLE;
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 3'd0;
            data_r  <= {DATA_BITS{1'b0}};
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            pbit_r  <= 1'b0;
            brk_r   <= 1'b0;
`endif
        end else begin
            sync1_r <= i_uart_rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            state_r <= state_s;
            if (sample_s || state_r == S_IDLE) cnt_r <= {CW{1'b0}};
            else                               cnt_r <= cnt_r + CW'(1);
            if (state_r != state_s)                                   bit_r <= 3'd0;
            else if (sample_s && (state_r == S_DATA || state_r == S_STOP)) bit_r <= bit_r + 3'd1;
            if (state_r == S_DATA && sample_s) data_r <= {sync2_r, data_r[DATA_BITS-1:1]};
            if (state_r == S_IDLE) begin
                perr_r <= 1'b0;
                ferr_r <= 1'b0;
            end else if (state_r == S_PAR && sample_s) begin
                perr_r <= par_err(data_r, sync2_r);
            end else if (state_r == S_STOP && sample_s) begin
                ferr_r <= ferr_r | ~sync2_r;
            end
`ifdef UART_RX_BREAK_DETECT_EN
            if (state_r == S_IDLE)                pbit_r <= 1'b0;
            else if (state_r == S_PAR && sample_s) pbit_r <= sync2_r;
            brk_r <= brk_s;
`endif
        end
    end

    // The frame's last stop sample is folded into ferr on the push cycle.
    assign wdata_s  = {perr_r, ferr_r | ~sync2_r, 8'(data_r)};
    assign pop_s    = rx_en_r & rx_rdy;
    assign full_s   = (wr_ptr_r[ASIZE] != rd_ptr_r[ASIZE]) &&
                      (wr_ptr_r[ASIZE-1:0] == rd_ptr_r[ASIZE-1:0]);
    assign acc_s    = push_s & (~full_s | pop_s);
    assign wr_nxt_s = wr_ptr_r + {{ASIZE{1'b0}}, acc_s};
    assign rd_nxt_s = rd_ptr_r + {{ASIZE{1'b0}}, pop_s};

    // FIFO storage, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (acc_s) mem_r[wr_ptr_r[ASIZE-1:0]] <= wdata_s;
    end

    // Pointers, registered head (with write bypass) and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r   <= {(ASIZE+1){1'b0}};
            rd_ptr_r   <= {(ASIZE+1){1'b0}};
            rx_en_r    <= 1'b0;
            data_out_r <= 8'h00;
            perr_out_r <= 1'b0;
            ferr_out_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            wr_ptr_r <= wr_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            rx_en_r  <= (wr_nxt_s != rd_nxt_s);
            if (wr_nxt_s != rd_nxt_s) begin
                if (acc_s && wr_ptr_r[ASIZE-1:0] == rd_nxt_s[ASIZE-1:0])
                    {perr_out_r, ferr_out_r, data_out_r} <= wdata_s;
                else
                    {perr_out_r, ferr_out_r, data_out_r} <= mem_r[rd_nxt_s[ASIZE-1:0]];
            end
            if (push_s && full_s && !pop_s) ovf_r <= 1'b1;
            else if (ovf_clr)               ovf_r <= 1'b0;
        end
    end

    assign rx_data     = data_out_r;
    assign rx_perr     = perr_out_r;
    assign rx_ferr     = ferr_out_r;
    assign rx_en       = rx_en_r;
    assign rx_overflow = ovf_r;
`ifdef UART_RX_BREAK_DETECT_EN
    assign rx_break    = brk_r;
`else
    assign rx_break    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: four instances cover 8N1, 7E1, two stop bits and a 4-deep FIFO.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [3:0]      line, rdy, clr;
    logic [3:0][7:0] dat;
    logic [3:0]      perr, ferr, en, ovf, brk;
    int              n_cmp = 0;
    int              n_err = 0;
    int              brk_cyc = 0;
    logic [9:0]      q0 [$];

    uart_rx_fifo #(.CLK_DIV(217)) u_main (
        .clk(clk), .rstn(rstn), .i_uart_rx(line[0]), .rx_data(dat[0]), .rx_perr(perr[0]),
        .rx_ferr(ferr[0]), .rx_en(en[0]), .rx_rdy(rdy[0]), .rx_overflow(ovf[0]),
        .ovf_clr(clr[0]), .rx_break(brk[0]));
    uart_rx_fifo #(.CLK_DIV(32), .DATA_BITS(7), .PARITY("EVEN")) u_par (
        .clk(clk), .rstn(rstn), .i_uart_rx(line[1]), .rx_data(dat[1]), .rx_perr(perr[1]),
        .rx_ferr(ferr[1]), .rx_en(en[1]), .rx_rdy(rdy[1]), .rx_overflow(ovf[1]),
        .ovf_clr(clr[1]), .rx_break(brk[1]));
    uart_rx_fifo #(.CLK_DIV(32), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rstn(rstn), .i_uart_rx(line[2]), .rx_data(dat[2]), .rx_perr(perr[2]),
        .rx_ferr(ferr[2]), .rx_en(en[2]), .rx_rdy(rdy[2]), .rx_overflow(ovf[2]),
        .ovf_clr(clr[2]), .rx_break(brk[2]));
    uart_rx_fifo #(.CLK_DIV(32), .ASIZE(2)) u_small (
        .clk(clk), .rstn(rstn), .i_uart_rx(line[3]), .rx_data(dat[3]), .rx_perr(perr[3]),
        .rx_ferr(ferr[3]), .rx_en(en[3]), .rx_rdy(rdy[3]), .rx_overflow(ovf[3]),
        .ovf_clr(clr[3]), .rx_break(brk[3]));

    // Record every handshake and break cycle of the main instance.
    always @(negedge clk) begin
        if (en[0] && rdy[0]) q0.push_back({perr[0], ferr[0], dat[0]});
        if (brk[0]) brk_cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input int div, input int nbits, input logic [7:0] data,
                        input bit has_par, input logic pbit, input int nstop, input logic [1:0] stopv);
        line[idx] = 1'b0;
        step(div);
        for (int i = 0; i < nbits; i++) begin
            line[idx] = data[i];
            step(div);
        end
        if (has_par) begin
            line[idx] = pbit;
            step(div);
        end
        for (int i = 0; i < nstop; i++) begin
            line[idx] = stopv[i];
            step(div);
        end
        line[idx] = 1'b1;
    endtask

    task automatic pop(input int idx);
        rdy[idx] = 1'b1;
        step(1);
        rdy[idx] = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0; line = 4'hF; rdy = 4'h0; clr = 4'h0;
        step(4);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({en[i], ovf[i], perr[i], ferr[i], brk[i], dat[i]} !== 13'h0) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h expected 0", i, {en[i], ovf[i], perr[i], ferr[i], brk[i], dat[i]});
            end
        end
        rstn = 1'b1;
        step(4);
    endtask

    task automatic test_8n1;
        logic [9:0] exp [3];
        logic [9:0] got;
        exp[0] = 10'h055; exp[1] = 10'h0A3; exp[2] = 10'h000;
        q0.delete();
        rdy[0] = 1'b1;
        send(0, 217, 8, 8'h55, 1'b0, 1'b0, 1, 2'b11);
        send(0, 217, 8, 8'hA3, 1'b0, 1'b0, 1, 2'b11);
        send(0, 217, 8, 8'h00, 1'b0, 1'b0, 1, 2'b11);
        step(20);
        rdy[0] = 1'b0;
        n_cmp++;
        if (q0.size() !== 3) begin
            n_err++;
            $display("FAIL 8n1_count: got %0d expected 3", q0.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < q0.size()) ? q0[i] : 10'h3FF;
            n_cmp++;
            if (got !== exp[i]) begin
                n_err++;
                $display("FAIL 8n1_byte%0d: got %h expected %h", i, got, exp[i]);
            end
        end
        q0.delete();
    endtask

    task automatic test_back_to_back;
        send(0, 217, 8, 8'hC6, 1'b0, 1'b0, 1, 2'b11);
        send(0, 217, 8, 8'h3C, 1'b0, 1'b0, 1, 2'b11);
        step(60);
        n_cmp++;
        if ({en[0], ferr[0], perr[0], dat[0]} !== {3'b100, 8'hC6}) begin
            n_err++;
            $display("FAIL b2b_head_hold: got %h expected %h", {en[0], ferr[0], perr[0], dat[0]}, {3'b100, 8'hC6});
        end
        pop(0);
        n_cmp++;
        if ({en[0], dat[0]} !== {1'b1, 8'h3C}) begin
            n_err++;
            $display("FAIL b2b_second: got %h expected %h", {en[0], dat[0]}, {1'b1, 8'h3C});
        end
        pop(0);
        n_cmp++;
        if (en[0] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_empty: got %b expected 0", en[0]);
        end
        q0.delete();
    endtask

    task automatic test_parity;
        send(1, 32, 7, 8'h41, 1'b1, 1'b1, 1, 2'b11);
        step(10);
        n_cmp++;
        if ({en[1], perr[1], ferr[1], dat[1]} !== {3'b110, 8'h41}) begin
            n_err++;
            $display("FAIL parity_bad: got %h expected %h", {en[1], perr[1], ferr[1], dat[1]}, {3'b110, 8'h41});
        end
        pop(1);
        send(1, 32, 7, 8'h43, 1'b1, 1'b1, 1, 2'b11);
        step(10);
        n_cmp++;
        if ({en[1], perr[1], ferr[1], dat[1]} !== {3'b100, 8'h43}) begin
            n_err++;
            $display("FAIL parity_good: got %h expected %h", {en[1], perr[1], ferr[1], dat[1]}, {3'b100, 8'h43});
        end
        pop(1);
    endtask

    task automatic test_stop2;
        send(2, 32, 8, 8'h5A, 1'b0, 1'b0, 2, 2'b01);
        step(32);
        send(2, 32, 8, 8'h12, 1'b0, 1'b0, 2, 2'b11);
        step(10);
        n_cmp++;
        if ({en[2], perr[2], ferr[2], dat[2]} !== {3'b101, 8'h5A}) begin
            n_err++;
            $display("FAIL stop2_ferr: got %h expected %h", {en[2], perr[2], ferr[2], dat[2]}, {3'b101, 8'h5A});
        end
        pop(2);
        n_cmp++;
        if ({en[2], perr[2], ferr[2], dat[2]} !== {3'b100, 8'h12}) begin
            n_err++;
            $display("FAIL stop2_clean: got %h expected %h", {en[2], perr[2], ferr[2], dat[2]}, {3'b100, 8'h12});
        end
        pop(2);
    endtask

    task automatic test_overflow;
        for (int k = 1; k <= 5; k++) send(3, 32, 8, 8'(k), 1'b0, 1'b0, 1, 2'b11);
        step(10);
        n_cmp++;
        if (ovf[3] !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: got %b expected 1", ovf[3]);
        end
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if ({en[3], dat[3]} !== {1'b1, 8'(k)}) begin
                n_err++;
                $display("FAIL ovf_drain%0d: got %h expected %h", k, {en[3], dat[3]}, {1'b1, 8'(k)});
            end
            pop(3);
        end
        n_cmp++;
        if ({en[3], ovf[3]} !== 2'b01) begin
            n_err++;
            $display("FAIL ovf_after_drain: got %b expected 01", {en[3], ovf[3]});
        end
        clr[3] = 1'b1;
        step(1);
        clr[3] = 1'b0;
        n_cmp++;
        if (ovf[3] !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b expected 0", ovf[3]);
        end
    endtask

    task automatic test_glitch;
        line[0] = 1'b0;
        step(100);
        line[0] = 1'b1;
        step(400);
        n_cmp++;
        if (en[0] !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_nopush: got %b expected 0", en[0]);
        end
        send(0, 217, 8, 8'h3C, 1'b0, 1'b0, 1, 2'b11);
        step(10);
        n_cmp++;
        if ({en[0], ferr[0], dat[0]} !== {2'b10, 8'h3C}) begin
            n_err++;
            $display("FAIL glitch_recover: got %h expected %h", {en[0], ferr[0], dat[0]}, {2'b10, 8'h3C});
        end
        pop(0);
        q0.delete();
    endtask

    task automatic test_break;
        brk_cyc = 0;
        line[0] = 1'b0;
        step(12 * 217);
        line[0] = 1'b1;
        step(300);
`ifdef UART_RX_BREAK_DETECT_EN
        n_cmp++;
        if (brk_cyc !== 1) begin
            n_err++;
            $display("FAIL break_pulse: got %0d cycles expected 1", brk_cyc);
        end
        n_cmp++;
        if (en[0] !== 1'b0) begin
            n_err++;
            $display("FAIL break_nopush: got %b expected 0", en[0]);
        end
`else
        n_cmp++;
        if (brk_cyc !== 0) begin
            n_err++;
            $display("FAIL break_tied: got %0d cycles expected 0", brk_cyc);
        end
        n_cmp++;
        if ({en[0], perr[0], ferr[0], dat[0]} !== {3'b101, 8'h00}) begin
            n_err++;
            $display("FAIL break_entry: got %h expected %h", {en[0], perr[0], ferr[0], dat[0]}, {3'b101, 8'h00});
        end
        pop(0);
        n_cmp++;
        if (en[0] !== 1'b0) begin
            n_err++;
            $display("FAIL break_single: got %b expected 0", en[0]);
        end
`endif
        q0.delete();
    endtask

    task automatic test_reset_mid;
        line[0] = 1'b0;
        step(217 * 4);
        rstn = 1'b0;
        line[0] = 1'b1;
        step(3);
        rstn = 1'b1;
        step(217 * 12);
        n_cmp++;
        if (en[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_nopush: got %b expected 0", en[0]);
        end
        send(0, 217, 8, 8'h81, 1'b0, 1'b0, 1, 2'b11);
        step(10);
        n_cmp++;
        if ({en[0], ferr[0], dat[0]} !== {2'b10, 8'h81}) begin
            n_err++;
            $display("FAIL reset_mid_recover: got %h expected %h", {en[0], ferr[0], dat[0]}, {2'b10, 8'h81});
        end
        pop(0);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_back_to_back();
        test_parity();
        test_stop2();
        test_overflow();
        test_glitch();
        test_break();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
